// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: one valid/ready pipeline stage that carries a data bundle
// and a control bundle. It supports backpressure and flush (bubble insertion),
// and optionally a one-entry skid buffer that registers in_ready.
// Control bits are forced to zero whenever the stage holds a bubble, so
// enables can never leak through a stall or a flush.
module pipe_stage_buf #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        count,
  output logic              err
);

  // Main entry: always drives the outputs.
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic [CTRL_W-1:0] r_m_ctrl;

  // Skid occupancy seen by the shared logic (constant 0 without a skid entry).
  logic              w_s_valid;

  logic              w_accept;
  logic              w_pop;

  assign w_accept = in_valid & in_ready & ~flush;
  assign w_pop    = r_m_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_s_valid;
      logic [DATA_W-1:0] r_s_data;
      logic [CTRL_W-1:0] r_s_ctrl;
      logic              r_in_ready;
      logic              w_s_valid_next;

      // Next skid occupancy; in_ready is registered from its inverse.
      always_comb begin
        w_s_valid_next = r_s_valid;
        if (flush) begin
          w_s_valid_next = 1'b0;
        end else if (w_pop && r_s_valid) begin
          w_s_valid_next = w_accept;
        end else if (!w_pop && r_m_valid && w_accept) begin
          w_s_valid_next = 1'b1;
        end
      end

      // Main/skid storage: the skid entry refills main on a pop, keeping order.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_m_valid  <= 1'b0;
          r_m_data   <= '0;
          r_m_ctrl   <= '0;
          r_s_valid  <= 1'b0;
          r_s_data   <= '0;
          r_s_ctrl   <= '0;
          r_in_ready <= 1'b1;
        end else begin
          r_s_valid  <= w_s_valid_next;
          r_in_ready <= ~w_s_valid_next;
          if (flush) begin
            r_m_valid <= 1'b0;
          end else if (w_pop && r_s_valid) begin
            r_m_valid <= 1'b1;
            r_m_data  <= r_s_data;
            r_m_ctrl  <= r_s_ctrl;
            if (w_accept) begin
              r_s_data <= in_data;
              r_s_ctrl <= in_ctrl;
            end
          end else if (w_accept) begin
            if (!r_m_valid || w_pop) begin
              r_m_valid <= 1'b1;
              r_m_data  <= in_data;
              r_m_ctrl  <= in_ctrl;
            end else begin
              r_s_data <= in_data;
              r_s_ctrl <= in_ctrl;
            end
          end else if (w_pop) begin
            r_m_valid <= 1'b0;
          end
        end
      end

      assign in_ready  = r_in_ready;
      assign w_s_valid = r_s_valid;
    end else begin : g_noskid
      // Single register: reload on accept, empty on a pop with no refill.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_m_ctrl  <= '0;
        end else if (flush) begin
          r_m_valid <= 1'b0;
        end else if (w_accept) begin
          r_m_valid <= 1'b1;
          r_m_data  <= in_data;
          r_m_ctrl  <= in_ctrl;
        end else if (w_pop) begin
          r_m_valid <= 1'b0;
        end
      end

      // Combinational ready: free when empty or when the head leaves this cycle.
      assign in_ready  = ~r_m_valid | out_ready;
      assign w_s_valid = 1'b0;
    end
  endgenerate

  // Upstream protocol monitor: remembers whether the previous cycle was
  // stalled and what was offered, so a withdrawn or altered entry is caught.
  logic              r_prev_stall;
  logic [DATA_W-1:0] r_prev_data;
  logic [CTRL_W-1:0] r_prev_ctrl;
  logic              r_err;
  logic              w_stall;
  logic              w_violation;

  assign w_stall     = in_valid & ~in_ready & ~flush;
  assign w_violation = r_prev_stall &
                       (~in_valid | (in_data != r_prev_data) | (in_ctrl != r_prev_ctrl));

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_stall <= 1'b0;
      r_prev_data  <= '0;
      r_prev_ctrl  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_prev_stall <= w_stall;
      r_prev_data  <= in_data;
      r_prev_ctrl  <= in_ctrl;
      if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign out_ctrl  = r_m_valid ? r_m_ctrl : '0;
  assign count     = {1'b0, r_m_valid} + {1'b0, w_s_valid};
  assign err       = r_err;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: one SKID=1 and one SKID=0 instance share the
// stimulus; 'mode' selects which one is compared against a FIFO reference.
module tb_pipe_stage_buf;
  localparam int DW = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_ready;
  logic          mode;

  logic          in_ready1, out_valid1, err1;
  logic [DW-1:0] out_data1;
  logic [CW-1:0] out_ctrl1;
  logic [1:0]    count1;
  logic          in_ready0, out_valid0, err0;
  logic [DW-1:0] out_data0;
  logic [CW-1:0] out_ctrl0;
  logic [1:0]    count0;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_ctrl(out_ctrl1), .count(count1), .err(err1)
  );

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) u_noskid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_ctrl(out_ctrl0), .count(count0), .err(err0)
  );

  logic          d_in_ready, d_out_valid, d_err;
  logic [DW-1:0] d_out_data;
  logic [CW-1:0] d_out_ctrl;
  logic [1:0]    d_count;
  assign d_in_ready  = mode ? in_ready1  : in_ready0;
  assign d_out_valid = mode ? out_valid1 : out_valid0;
  assign d_err       = mode ? err1       : err0;
  assign d_out_data  = mode ? out_data1  : out_data0;
  assign d_out_ctrl  = mode ? out_ctrl1  : out_ctrl0;
  assign d_count     = mode ? count1     : count0;

  // Reference: the stage is an in-order queue of capacity 2 (SKID=1) or 1.
  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  ent_t          mq[$];
  bit            m_err, m_prev_stall, m_last_acc;
  logic [DW-1:0] m_prev_data;
  logic [CW-1:0] m_prev_ctrl;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Compare outputs on the falling edge, then advance the model to the next edge.
  task automatic cycle();
    bit   ready, acc, pop, viol;
    int   sz;
    ent_t e;
    @(negedge clk);
    sz    = mq.size();
    ready = mode ? (sz < 2) : (sz == 0 || out_ready);
    check("in_ready", 64'(d_in_ready), 64'(ready));
    check("out_valid", 64'(d_out_valid), 64'(sz > 0));
    check("count", 64'(d_count), 64'(sz));
    check("err", 64'(d_err), 64'(m_err));
    if (sz > 0) begin
      e = mq[0];
      check("out_ctrl", 64'(d_out_ctrl), 64'(e.c));
      check("out_data", 64'(d_out_data), 64'(e.d));
    end else begin
      check("out_ctrl_bubble", 64'(d_out_ctrl), 64'(0));
    end
    acc  = in_valid && ready && !flush;
    pop  = (sz > 0) && out_ready;
    viol = m_prev_stall && (!in_valid || in_data !== m_prev_data || in_ctrl !== m_prev_ctrl);
    if (viol) m_err = 1'b1;
    m_prev_stall = in_valid && !ready && !flush;
    m_prev_data  = in_data;
    m_prev_ctrl  = in_ctrl;
    m_last_acc   = acc;
    if (flush) begin
      mq.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        e.d = in_data;
        e.c = in_ctrl;
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check the cleared outputs, release after an edge.
  task automatic do_reset();
    rst = 1'b1;
    mq.delete();
    m_err = 1'b0;
    m_prev_stall = 1'b0;
    #2;
    check("rst_out_valid", 64'(d_out_valid), 64'(0));
    check("rst_out_ctrl", 64'(d_out_ctrl), 64'(0));
    check("rst_out_data", 64'(d_out_data), 64'(0));
    check("rst_count", 64'(d_count), 64'(0));
    check("rst_in_ready", 64'(d_in_ready), 64'(1));
    check("rst_err", 64'(d_err), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int t = 0; t < n; t++) begin
      if (!m_prev_stall) begin
        in_valid = ($urandom % 4) != 0;
        in_data  = DW'($urandom);
        in_ctrl  = CW'($urandom);
      end
      out_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 16) == 0;
      cycle();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) cycle();
  endtask

  initial begin
    int idx;
    mode      = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h00AA;
    in_ctrl   = 8'hFF;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset with a valid input waiting; first edge after release accepts it.
    do_reset();
    cycle();
    check("post_rst_ctrl", 64'(d_out_ctrl), 64'(8'hFF));
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();

    // Streaming 1..8 back-to-back with out_ready high.
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      in_ctrl  = CW'(i);
      cycle();
    end
    in_valid = 1'b0;
    repeat (2) cycle();

    // Backpressure: drop out_ready once entry 1 is shown, then raise it.
    idx = 1;
    for (int t = 0; t < 14; t++) begin
      in_valid  = (idx <= 5);
      in_data   = DW'(idx);
      in_ctrl   = CW'(idx + 16);
      out_ready = !(t >= 1 && t <= 4);
      cycle();
      if (t == 2) begin
        check("bp_count_full", 64'(d_count), 64'(2));
        check("bp_in_ready_low", 64'(d_in_ready), 64'(0));
      end
      if (m_last_acc) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'(6));

    // Flush with two entries held and entry 7 offered in the flush cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011; in_ctrl = 8'h11; cycle();
    in_data = 16'h0022; in_ctrl = 8'h22; cycle();
    check("fl_count_2", 64'(d_count), 64'(2));
    in_data = 16'h0007; in_ctrl = 8'h03; flush = 1'b1; cycle();
    check("fl_count_0", 64'(d_count), 64'(0));
    check("fl_ctrl_0", 64'(d_out_ctrl), 64'(0));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    // Asynchronous reset while an entry is held: ctrl drops without an edge.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h00EE; in_ctrl = 8'h5A; cycle();
    in_valid = 1'b0;
    check("pre_rst_ctrl", 64'(d_out_ctrl), 64'(8'h5A));
    do_reset();

    // Protocol violation: data changes while stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0101; in_ctrl = 8'h01; cycle();
    in_data = 16'h0202; cycle();
    in_data = 16'h1234; in_ctrl = 8'h00; cycle();
    in_data = 16'h5678; cycle();
    cycle();
    check("err_set", 64'(d_err), 64'(1));
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    check("err_sticky", 64'(d_err), 64'(1));
    do_reset();

    // Same change with flush high does not raise err.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0101; in_ctrl = 8'h01; cycle();
    in_data = 16'h0202; cycle();
    flush = 1'b1;
    in_data = 16'h1234; in_ctrl = 8'h00; cycle();
    in_data = 16'h5678; cycle();
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) cycle();
    check("err_flush_clear", 64'(d_err), 64'(0));

    // Randomised traffic on the skid variant.
    random_phase(300);

    // SKID=0: out_ready toggles 1/0/1 with continuous input.
    mode = 1'b0;
    in_valid = 1'b0;
    do_reset();
    idx = 1;
    for (int t = 0; t < 15; t++) begin
      in_valid  = 1'b1;
      in_data   = DW'(idx + 100);
      in_ctrl   = CW'(idx);
      out_ready = (t % 3) != 1;
      cycle();
      if (m_last_acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) cycle();
    check("ns_accepted", 64'(idx), 64'(11));

    // Randomised traffic on the single-register variant.
    random_phase(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
